// File: rtl/button_counter.sv
// Debounced up/down/load push-button counter feeding the BCD-to-seven-segment converter.
// Build option: define BUTTON_COUNTER_WRAP_EN for modulo arithmetic (default saturates).
module button_counter #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int WIDTH           = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_load,
    input  logic [WIDTH-1:0] switches,
    output logic [WIDTH-1:0] value,
    output logic             changed
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam int               NBTN     = 3;
    localparam logic [19:0]      CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] VAL_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] VAL_MIN  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] VAL_ONE  = WIDTH'(1);
`ifdef BUTTON_COUNTER_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    // Bit order of the per-button vectors: [0]=up, [1]=down, [2]=load.
    logic [NBTN-1:0]  w_raw;
    logic [NBTN-1:0]  r_sync1;
    logic [NBTN-1:0]  r_sync2;
    state_t           r_state     [NBTN];
    state_t           w_state_nxt [NBTN];
    logic [19:0]      r_cnt       [NBTN];
    logic [19:0]      w_cnt_nxt   [NBTN];
    logic [NBTN-1:0]  w_evt;
    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] w_value_nxt;
    logic             r_changed;

    assign w_raw = {btn_load, btn_down, btn_up};

    // Synchronisers and debounce state/counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= {NBTN{1'b0}};
            r_sync2 <= {NBTN{1'b0}};
            for (int i = 0; i < NBTN; i++) begin
                r_state[i] <= IDLE;
                r_cnt[i]   <= 20'd0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < NBTN; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
        end
    end

    // Debounce next-state logic; the counter falls back to zero on any state change or glitch.
    always_comb begin
        for (int i = 0; i < NBTN; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = 20'd0;
            w_evt[i]       = 1'b0;
            case (r_state[i])
                IDLE: begin
                    if (r_sync2[i]) w_state_nxt[i] = PRESS_WAIT;
                    else            w_state_nxt[i] = IDLE;
                end
                PRESS_WAIT: begin
                    if (!r_sync2[i]) begin
                        w_state_nxt[i] = IDLE;
                    end else if (r_cnt[i] == CNT_LAST) begin
                        w_state_nxt[i] = PRESSED;
                        w_evt[i]       = 1'b1;
                    end else begin
                        w_cnt_nxt[i]   = r_cnt[i] + 20'd1;
                    end
                end
                PRESSED: begin
                    if (!r_sync2[i]) w_state_nxt[i] = RELEASE_WAIT;
                    else             w_state_nxt[i] = PRESSED;
                end
                RELEASE_WAIT: begin
                    if (r_sync2[i]) begin
                        w_state_nxt[i] = PRESSED;
                    end else if (r_cnt[i] == CNT_LAST) begin
                        w_state_nxt[i] = IDLE;
                    end else begin
                        w_cnt_nxt[i]   = r_cnt[i] + 20'd1;
                    end
                end
                default: begin
                    w_state_nxt[i] = IDLE;
                end
            endcase
        end
    end

    // Value update: load wins, simultaneous up+down cancel, limits saturate unless wrapping.
    always_comb begin
        w_value_nxt = r_value;
        if (w_evt[2]) begin
            w_value_nxt = switches;
        end else if (w_evt[0] && w_evt[1]) begin
            w_value_nxt = r_value;
        end else if (w_evt[0]) begin
            if ((r_value == VAL_MAX) && !WRAP_EN) w_value_nxt = r_value;
            else                                  w_value_nxt = r_value + VAL_ONE;
        end else if (w_evt[1]) begin
            if ((r_value == VAL_MIN) && !WRAP_EN) w_value_nxt = r_value;
            else                                  w_value_nxt = r_value - VAL_ONE;
        end else begin
            w_value_nxt = r_value;
        end
    end

    // Output registers; changed flags only a real change of the stored value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value   <= {WIDTH{1'b0}};
            r_changed <= 1'b0;
        end else begin
            r_value   <= w_value_nxt;
            r_changed <= (w_value_nxt != r_value);
        end
    end

    assign value   = r_value;
    assign changed = r_changed;

endmodule

// File: tb/tb_button_counter.sv
// Directed bench for button_counter with DEBOUNCE_CYCLES=4, WIDTH=4.
// Expectations follow BUTTON_COUNTER_WRAP_EN when the bench is built with it.
module tb_button_counter;

    localparam int DC = 4;
    localparam int W  = 4;
`ifdef BUTTON_COUNTER_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         btn_up   = 1'b0;
    logic         btn_down = 1'b0;
    logic         btn_load = 1'b0;
    logic [W-1:0] switches = 4'd0;
    logic [W-1:0] value;
    logic         changed;

    int n_checks = 0;
    int n_fail   = 0;
    int n_chg    = 0;
    int c0       = 0;

    button_counter #(.DEBOUNCE_CYCLES(DC), .WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_load (btn_load),
        .switches (switches),
        .value    (value),
        .changed  (changed)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, sampling 1 time unit after each and tallying changed pulses.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (changed === 1'b1) n_chg++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // m = {load, down, up}: hold for 'hold' edges, then low for 'low' edges.
    task automatic press(input logic [2:0] m, input int hold, input int low);
        {btn_load, btn_down, btn_up} = m;
        step(hold);
        {btn_load, btn_down, btn_up} = 3'b000;
        step(low);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step(3);
        check("reset_value", value, 32'd0);
        check("reset_changed", changed, 32'd0);
        rst = 1'b0;
        n_chg = 0;

        // Clean press: update exactly DC+3 edges after the first sampled 1
        btn_up = 1'b1;
        step(DC + 2);
        check("up_before_latency", value, 32'd0);
        check("up_no_early_pulse", n_chg, 32'd0);
        step(1);
        check("up_at_latency", value, 32'd1);
        check("up_changed_pulse", changed, 32'd1);
        step(1);
        check("up_changed_one_cycle", changed, 32'd0);
        step(2);
        btn_up = 1'b0;
        step(12);
        check("up_final", value, 32'd1);
        check("up_pulse_count", n_chg, 32'd1);

        // Bouncing down press: one event only
        c0 = n_chg;
        btn_down = 1'b1; step(1);
        btn_down = 1'b0; step(1);
        btn_down = 1'b1; step(1);
        btn_down = 1'b0; step(1);
        btn_down = 1'b1; step(8);
        btn_down = 1'b0; step(12);
        check("bounce_value", value, 32'd0);
        check("bounce_pulses", n_chg - c0, 32'd1);

        // Long hold gives a single increment; re-press after 6 low cycles counts again
        c0 = n_chg;
        press(3'b001, 50, 6);
        check("hold_value", value, 32'd1);
        check("hold_pulses", n_chg - c0, 32'd1);
        press(3'b001, 10, 12);
        check("repress_value", value, 32'd2);
        check("repress_pulses", n_chg - c0, 32'd2);

        // Load, then load colliding with up
        switches = 4'b1001;
        press(3'b100, 10, 12);
        check("load_9", value, 32'd9);
        c0 = n_chg;
        switches = 4'b0011;
        press(3'b101, 10, 12);
        check("load_beats_up", value, 32'd3);
        check("load_up_pulses", n_chg - c0, 32'd1);

        // Upper limit
        switches = 4'b1111;
        press(3'b100, 10, 12);
        check("load_15", value, 32'd15);
        c0 = n_chg;
        press(3'b001, 10, 12);
        check("up_at_max", value, WRAP ? 32'd0 : 32'd15);
        check("up_at_max_pulses", n_chg - c0, WRAP ? 32'd1 : 32'd0);

        // Lower limit (loading the current value must not pulse)
        c0 = n_chg;
        switches = 4'b0000;
        press(3'b100, 10, 12);
        check("load_0", value, 32'd0);
        check("load_0_pulses", n_chg - c0, WRAP ? 32'd0 : 32'd1);
        c0 = n_chg;
        press(3'b010, 10, 12);
        check("down_at_min", value, WRAP ? 32'd15 : 32'd0);
        check("down_at_min_pulses", n_chg - c0, WRAP ? 32'd1 : 32'd0);

        // Simultaneous up and down cancel
        switches = 4'b0101;
        press(3'b100, 10, 12);
        check("load_5", value, 32'd5);
        c0 = n_chg;
        press(3'b011, 10, 12);
        check("updown_value", value, 32'd5);
        check("updown_pulses", n_chg - c0, 32'd0);

        // Reset while PRESS_WAIT count is 2, button held through reset
        c0 = n_chg;
        btn_up = 1'b1;
        step(5);
        rst = 1'b1;
        step(2);
        check("midrst_value", value, 32'd0);
        rst = 1'b0;
        step(DC + 2);
        check("midrst_before", value, 32'd0);
        check("midrst_no_pulse", n_chg - c0, 32'd0);
        step(1);
        check("midrst_after", value, 32'd1);
        check("midrst_changed", changed, 32'd1);
        step(1);
        check("midrst_changed_one", changed, 32'd0);
        btn_up = 1'b0;
        step(12);
        check("midrst_pulses", n_chg - c0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
